// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared exception cause codes and stage indices for the pipeline.
// Revision    : 1.0
// ============================================================================
package pipe_pkg;

    typedef enum logic [2:0] {
        EXC_NONE  = 3'd0,
        EXC_OV    = 3'd1,
        EXC_UNDEF = 3'd2,
        EXC_ADDR  = 3'd3
    } exc_cause_e;

    localparam int ST_ID  = 0;
    localparam int ST_EX  = 1;
    localparam int ST_MEM = 2;
    localparam int ST_WB  = 3;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : One pipeline register: valid/pc/payload with load, hold, clear.
// Revision    : 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_WIDTH   = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Clear covers both kill and "entry left without replacement".
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_chain
// Description : N-stage in-order pipeline with stall, flush, precise exceptions.
//               Optional perf counters when PIPE_PERF_EN is defined.
// Revision    : 1.0
// ============================================================================
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int STAGES      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int PC_WIDTH    = 6,
    parameter int CAUSE_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PC_WIDTH-1:0]             in_pc,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic [STAGES-1:0]               stall_req,
    input  logic [STAGES-1:0]               flush_req,
    input  logic [STAGES-1:0]               exc_req,
    input  logic [STAGES*CAUSE_WIDTH-1:0]   exc_cause_i,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PC_WIDTH-1:0]             out_pc,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [STAGES-1:0]               stage_valid,
    output logic [STAGES*PC_WIDTH-1:0]      stage_pc,
    output logic [STAGES*DATA_WIDTH-1:0]    stage_data,
    output logic                            exc_valid,
    output logic [PC_WIDTH-1:0]             exc_pc,
    output logic [CAUSE_WIDTH-1:0]          exc_cause,
    output logic [CNT_WIDTH-1:0]            perf_stall,
    output logic [CNT_WIDTH-1:0]            perf_flush
);

    logic [STAGES-1:0]     valid, adv, acc, kill, exc_live, load, clear;
    logic [PC_WIDTH-1:0]   pc_a   [STAGES];
    logic [DATA_WIDTH-1:0] data_a [STAGES];
    logic                  down_ok, kill_run, in_fire;

    assign exc_live = exc_req & valid;

    // Acceptance ripples from the oldest stage down; kill spreads from the
    // highest flush/exception index down to stage 0.
    always_comb begin
        down_ok  = out_ready;
        kill_run = 1'b0;
        adv      = '0;
        acc      = '0;
        kill     = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]   = valid[i] & ~stall_req[i] & down_ok;
            acc[i]   = ~valid[i] | adv[i];
            down_ok  = acc[i];
            kill_run = kill_run | flush_req[i] | exc_live[i];
            kill[i]  = kill_run;
        end
    end

    assign in_ready = acc[0] & ~(|flush_req) & ~(|exc_live);
    assign in_fire  = in_valid & in_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [PC_WIDTH-1:0]   src_pc;
        logic [DATA_WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign load[i]  = in_fire;
            assign src_pc   = in_pc;
            assign src_data = in_data;
        end else begin : g_body
            // A killed predecessor never hands its entry forward.
            assign load[i]  = adv[i-1] & ~kill[i-1];
            assign src_pc   = pc_a[i-1];
            assign src_data = data_a[i-1];
        end

        assign clear[i] = kill[i] | (adv[i] & ~load[i]);

        pipe_stage_reg #(
            .PC_WIDTH   (PC_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[i]),
            .clear_i (clear[i]),
            .pc_i    (src_pc),
            .data_i  (src_data),
            .valid_o (valid[i]),
            .pc_o    (pc_a[i]),
            .data_o  (data_a[i])
        );

        assign stage_pc[i*PC_WIDTH +: PC_WIDTH]       = pc_a[i];
        assign stage_data[i*DATA_WIDTH +: DATA_WIDTH] = data_a[i];
    end

    assign stage_valid = valid;
    assign out_valid   = valid[STAGES-1];
    assign out_pc      = pc_a[STAGES-1];
    assign out_data    = data_a[STAGES-1];

    logic                   exc_valid_q, exc_valid_d;
    logic [PC_WIDTH-1:0]    exc_pc_q, exc_pc_d;
    logic [CAUSE_WIDTH-1:0] exc_cause_q, exc_cause_d;

    // Ascending scan: the last hit is the oldest excepting stage.
    always_comb begin
        exc_valid_d = |exc_live;
        exc_pc_d    = exc_pc_q;
        exc_cause_d = exc_cause_q;
        for (int i = 0; i < STAGES; i++) begin
            if (exc_live[i]) begin
                exc_pc_d    = pc_a[i];
                exc_cause_d = exc_cause_i[i*CAUSE_WIDTH +: CAUSE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_valid_q <= 1'b0;
            exc_pc_q    <= '0;
            exc_cause_q <= '0;
        end else begin
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    assign exc_valid = exc_valid_q;
    assign exc_pc    = exc_pc_q;
    assign exc_cause = exc_cause_q;

`ifdef PIPE_PERF_EN
    logic [CNT_WIDTH-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_WIDTH-1:0] perf_flush_q, perf_flush_d;
    logic [CNT_WIDTH:0]   kill_cnt, flush_sum;
    logic [STAGES-1:0]    kill_valid;

    assign kill_valid = kill & valid;

    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            kill_cnt = kill_cnt + {{CNT_WIDTH{1'b0}}, kill_valid[i]};
        end
        flush_sum    = {1'b0, perf_flush_q} + kill_cnt;
        perf_flush_d = flush_sum[CNT_WIDTH] ? '1 : flush_sum[CNT_WIDTH-1:0];
        perf_stall_d = perf_stall_q;
        if ((|(stall_req & valid)) && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_chain
// Description : Directed scoreboard bench for pipe_stage_chain (STAGES=4).
// Revision    : 1.0
// ============================================================================
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    localparam int S  = 4;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int CW = 3;
    localparam int NW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready, exc_valid;
    logic [PW-1:0]   in_pc, out_pc, exc_pc;
    logic [DW-1:0]   in_data, out_data;
    logic [S-1:0]    stall_req, flush_req, exc_req, stage_valid;
    logic [S*CW-1:0] exc_cause_i;
    logic [S*PW-1:0] stage_pc;
    logic [S*DW-1:0] stage_data;
    logic [CW-1:0]   exc_cause;
    logic [NW-1:0]   perf_stall, perf_flush;

    always #5 clk = ~clk;

    pipe_stage_chain #(
        .STAGES(S), .DATA_WIDTH(DW), .PC_WIDTH(PW), .CAUSE_WIDTH(CW), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .stall_req(stall_req), .flush_req(flush_req), .exc_req(exc_req),
        .exc_cause_i(exc_cause_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .stage_valid(stage_valid), .stage_pc(stage_pc), .stage_data(stage_data),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_cause(exc_cause),
        .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic ir_seen;
    logic acc_seen;

    function automatic logic [DW-1:0] mk(input int pc);
        return 32'hA500_0000 ^ (pc * 32'h0101_0101);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, then step past the rising edge.
    task automatic cyc();
        ent_t e;
        @(negedge clk);
        ir_seen  = in_ready;
        acc_seen = 1'b0;
        if (!rst) begin
            if (in_valid && in_ready) begin
                e.pc   = in_pc;
                e.data = in_data;
                q.push_back(e);
                acc_seen = 1'b1;
            end
            if (out_valid && out_ready && !stall_req[S-1] && !flush_req[S-1] && !exc_req[S-1]) begin
                chk("retire_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("ret_pc", 64'(out_pc), 64'(e.pc));
                    chk("ret_data", 64'(out_data), 64'(e.data));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int pc);
        in_valid = 1'b1;
        in_pc    = PW'(pc);
        in_data  = mk(pc);
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (acc_seen) break;
        end
        chk("offer_accept", 64'(acc_seen), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall_req = '0;
        flush_req = '0;
        exc_req   = '0;
        for (int k = 0; k < 30; k++) begin
            if (q.size() == 0) break;
            cyc();
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_outv", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_data = '0; out_ready = 1'b1;
        stall_req = '0; flush_req = '0; exc_req = '0; exc_cause_i = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_stage_valid", 64'(stage_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_exc_valid", 64'(exc_valid), 64'd0);
        chk("rst_exc_pc", 64'(exc_pc), 64'd0);
        chk("rst_exc_cause", 64'(exc_cause), 64'd0);
        chk("rst_perf_stall", 64'(perf_stall), 64'd0);
        chk("rst_perf_flush", 64'(perf_flush), 64'd0);

        // Streaming: first output three edges after accept, then one per cycle.
        for (int i = 1; i <= 8; i++) begin
            offer(i);
            chk("t1_ready", 64'(ir_seen), 64'd1);
            chk("t1_outv", 64'(out_valid), 64'(i >= 4));
        end
        drain();

        // Stall stage 1 with a full pipe: stage 2 becomes a bubble.
        for (int i = 11; i <= 14; i++) offer(i);
        in_valid = 1'b1; in_pc = 6'd15; in_data = mk(15); stall_req = 4'b0010;
        cyc();
        stall_req = '0; in_valid = 1'b0;
        chk("t2_ready", 64'(ir_seen), 64'd0);
        chk("t2_valid", 64'(stage_valid), 64'b1011);
        chk("t2_pc0", 64'(stage_pc[5:0]), 64'd14);
        chk("t2_pc1", 64'(stage_pc[11:6]), 64'd13);
        chk("t2_pc3", 64'(stage_pc[23:18]), 64'd12);
        offer(15); offer(16);
        drain();

        // Back-pressure: only four entries fit while the consumer stalls.
        out_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_pc = PW'(21 + cnt); in_data = mk(21 + cnt);
            cyc();
            if (acc_seen) cnt++;
        end
        in_valid = 1'b0;
        chk("t3_accepts", 64'(cnt), 64'd4);
        chk("t3_ready_low", 64'(ir_seen), 64'd0);
        chk("t3_valid", 64'(stage_valid), 64'b1111);
        chk("t3_hold_pc", 64'(out_pc), 64'd21);
        out_ready = 1'b1;
        for (int i = 25; i <= 28; i++) offer(i);
        drain();

        // Two exceptions in one cycle: the older (stage 2) wins.
        for (int i = 31; i <= 34; i++) offer(i);
        exc_req = 4'b0110;
        exc_cause_i = '0;
        exc_cause_i[8:6] = EXC_OV;
        exc_cause_i[5:3] = EXC_UNDEF;
        cyc();
        exc_req = '0;
        repeat (3) void'(q.pop_back());
        chk("t4_ready", 64'(ir_seen), 64'd0);
        chk("t4_exc_valid", 64'(exc_valid), 64'd1);
        chk("t4_exc_cause", 64'(exc_cause), 64'd1);
        chk("t4_exc_pc", 64'(exc_pc), 64'd32);
        chk("t4_valid", 64'(stage_valid), 64'b0000);
        cyc();
        chk("t4_pulse_end", 64'(exc_valid), 64'd0);
        chk("t4_pc_hold", 64'(exc_pc), 64'd32);
        chk("t4_cause_hold", 64'(exc_cause), 64'd1);
        drain();

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        q.delete();

        // Flush stages 0..1 while stage 0 also requests a stall.
        for (int i = 41; i <= 44; i++) offer(i);
        in_valid = 1'b1; in_pc = 6'd45; in_data = mk(45);
        flush_req = 4'b0010; stall_req = 4'b0001;
        cyc();
        flush_req = '0; stall_req = '0; in_valid = 1'b0;
        repeat (2) void'(q.pop_back());
        chk("t5_ready", 64'(ir_seen), 64'd0);
        chk("t5_valid", 64'(stage_valid), 64'b1000);
        chk("t5_pc3", 64'(stage_pc[23:18]), 64'd42);
`ifdef PIPE_PERF_EN
        chk("t5_perf_flush", 64'(perf_flush), 64'd2);
        chk("t5_perf_stall", 64'(perf_stall), 64'd1);
`else
        chk("t5_perf_flush", 64'(perf_flush), 64'd0);
        chk("t5_perf_stall", 64'(perf_stall), 64'd0);
`endif
        drain();

        // Reset mid-stream after an exception on stage 0.
        for (int i = 51; i <= 53; i++) offer(i);
        exc_req = 4'b0001;
        exc_cause_i = '0;
        exc_cause_i[2:0] = EXC_ADDR;
        cyc();
        exc_req = '0;
        void'(q.pop_back());
        chk("t6_exc_pc", 64'(exc_pc), 64'd53);
        chk("t6_exc_cause", 64'(exc_cause), 64'd3);
        rst = 1'b1; in_valid = 1'b1; in_pc = 6'd54; in_data = mk(54);
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("t6_valid", 64'(stage_valid), 64'd0);
        chk("t6_exc_valid", 64'(exc_valid), 64'd0);
        chk("t6_exc_pc0", 64'(exc_pc), 64'd0);
        chk("t6_exc_cause0", 64'(exc_cause), 64'd0);
        chk("t6_perf_stall", 64'(perf_stall), 64'd0);
        chk("t6_perf_flush", 64'(perf_flush), 64'd0);
        offer(60);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
